// File: rtl/barrel_shifter_drain_pkg.sv
// barrel_shifter_drain_pkg: shared constants and element-slice helper for the shifter and its drain
package barrel_shifter_drain_pkg;
    localparam int N = 16;
    localparam int WIDTH = 8;
    localparam int K = $clog2(N);
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int VEC_W = N * WIDTH;

    function automatic int elem_lsb(input int e);
        return e * WIDTH;
    endfunction
endpackage

// File: rtl/barrel_shifter_drain_if.sv
// barrel_shifter_drain_if: vector input, element stream output and status of the drain
interface barrel_shifter_drain_if;
    import barrel_shifter_drain_pkg::*;
    logic             in_valid;
    logic [VEC_W-1:0] in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [K-1:0]     out_idx;
    logic             out_last;
    logic [CNT_W-1:0] free_slots;
    logic             overflow;
    modport master (
        output in_valid, in, out_ready,
        input  out_valid, out_data, out_idx, out_last, free_slots, overflow
    );
    modport slave (
        input  in_valid, in, out_ready,
        output out_valid, out_data, out_idx, out_last, free_slots, overflow
    );
endinterface

// File: rtl/bs_vec_fifo.sv
// bs_vec_fifo: DEPTH x VEC_W register FIFO; caller guarantees push only when not full or popping
module bs_vec_fifo
    import barrel_shifter_drain_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [VEC_W-1:0] wdata,
    output logic [VEC_W-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [VEC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= (push && !pop) ? count + CNT_W'(1) :
                     (pop && !push) ? count - CNT_W'(1) : count;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/barrel_shifter_drain.sv
// barrel_shifter_drain: buffers rotated vectors and streams their elements one per cycle
module barrel_shifter_drain
    import barrel_shifter_drain_pkg::*;
(
    input logic clk,
    input logic rst,
    barrel_shifter_drain_if.slave bus
);
    logic [VEC_W-1:0] rdata;
    logic [CNT_W-1:0] count;
    logic [K-1:0]     elem_idx;
    logic             full, empty, hs, last, pop, push, overflow;

    assign last = elem_idx == K'(N - 1);
    assign hs   = !empty && bus.out_ready;
    assign pop  = hs && last;
    // a full FIFO can still take a vector when its head leaves on the same edge
    assign push = bus.in_valid && (!full || pop);

    bs_vec_fifo u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(bus.in),
        .rdata(rdata), .full(full), .empty(empty), .count(count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_idx <= '0;
            overflow <= 1'b0;
        end else begin
            if (hs) elem_idx <= last ? '0 : elem_idx + K'(1);
            if (bus.in_valid && !push) overflow <= 1'b1;
        end
    end

    assign bus.out_valid  = !empty;
    assign bus.out_data   = empty ? '0 : rdata[elem_lsb(int'(elem_idx)) +: WIDTH];
    assign bus.out_idx    = elem_idx;
    assign bus.out_last   = !empty && last;
    assign bus.free_slots = CNT_W'(DEPTH) - count;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_barrel_shifter_drain.sv
// tb_barrel_shifter_drain: scoreboard bench, expected elements queued at write and checked as they stream out
module tb_barrel_shifter_drain;
    import barrel_shifter_drain_pkg::*;

    logic clk, rst;
    barrel_shifter_drain_if bus();
    barrel_shifter_drain dut (.clk(clk), .rst(rst), .bus(bus));

    int applied = 0;
    int miscompares = 0;
    int mcount = 0;
    int midx = 0;
    bit movf = 0;
    logic [WIDTH-1:0] q[$];
    logic [13:0] exp_s, got_s;
    localparam logic [VEC_W-1:0] ZERO = '0;

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VEC_W-1:0] mkvec(input logic [7:0] base);
        logic [VEC_W-1:0] v;
        for (int e = 0; e < N; e++) v[e*WIDTH +: WIDTH] = base + 8'(e);
        return v;
    endfunction

    function automatic logic [13:0] expect_stream();
        return {mcount != 0, mcount != 0 ? q[0] : 8'h00, 4'(midx), mcount != 0 && midx == N - 1};
    endfunction

    // drives one cycle and advances the reference model across the edge
    task automatic drive_cycle(input logic v, input logic [VEC_W-1:0] d, input logic rdy);
        bit hs, pop, push;
        bus.in_valid = v;
        bus.in = d;
        bus.out_ready = rdy;
        hs = mcount != 0 && rdy;
        pop = hs && midx == N - 1;
        push = v && (mcount < DEPTH || pop);
        if (v && !push) movf = 1;
        @(posedge clk);
        if (hs) begin
            void'(q.pop_front());
            midx = pop ? 0 : midx + 1;
        end
        if (push) for (int e = 0; e < N; e++) q.push_back(d[e*WIDTH +: WIDTH]);
        mcount = mcount + int'(push) - int'(pop);
        #1;
    endtask

    task automatic model_reset();
        mcount = 0;
        midx = 0;
        movf = 0;
        q.delete();
    endtask

    task automatic apply_reset();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        bus.in_valid = 0;
        bus.in = '0;
        bus.out_ready = 0;
        rst = 1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        got_s = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
        applied++;
        if (got_s !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_stream: got %h want %h", got_s, 14'h0);
        end
        applied++;
        if ({bus.free_slots, bus.overflow} !== {3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_status: got free=%0d ovf=%b want free=4 ovf=0", bus.free_slots, bus.overflow);
        end
        drive_cycle(0, ZERO, 1);
        applied++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_single();
        drive_cycle(1, mkvec(8'h00), 1);
        for (int i = 0; i < N; i++) begin
            exp_s = expect_stream();
            got_s = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
            applied++;
            if (got_s !== exp_s || bus.out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL single[%0d]: got %h want %h", i, got_s, exp_s);
            end
            drive_cycle(0, ZERO, 1);
        end
        applied++;
        if ({bus.out_valid, bus.free_slots} !== {1'b0, 3'd4}) begin
            miscompares++;
            $display("FAIL single_end: got valid=%b free=%0d want valid=0 free=4", bus.out_valid, bus.free_slots);
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] prev;
        bit prev_rdy;
        bit rdy;
        int i;
        drive_cycle(1, mkvec(8'hA0), 0);
        prev_rdy = 1;
        prev = '0;
        for (i = 0; i < 100 && mcount != 0; i++) begin
            rdy = (i % 3) == 0;
            exp_s = expect_stream();
            got_s = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
            applied++;
            if (got_s !== exp_s) begin
                miscompares++;
                $display("FAIL bp[%0d]: got %h want %h", i, got_s, exp_s);
            end
            if (!prev_rdy) begin
                applied++;
                if (got_s !== prev) begin
                    miscompares++;
                    $display("FAIL bp_hold[%0d]: got %h want %h", i, got_s, prev);
                end
            end
            prev = got_s;
            prev_rdy = rdy;
            drive_cycle(0, ZERO, rdy);
        end
        applied++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end: got valid=%b want 0 after %0d cycles", bus.out_valid, i);
        end
    endtask

    task automatic test_fill();
        for (int v = 0; v < DEPTH; v++) begin
            drive_cycle(1, mkvec(8'(8'h10 * (v + 1))), 0);
            applied++;
            if (bus.free_slots !== 3'(DEPTH - 1 - v)) begin
                miscompares++;
                $display("FAIL fill_free[%0d]: got %0d want %0d", v, bus.free_slots, DEPTH - 1 - v);
            end
        end
        drive_cycle(1, mkvec(8'hF0), 0);
        applied++;
        if ({bus.overflow, bus.free_slots} !== {1'b1, 3'd0} || movf != 1) begin
            miscompares++;
            $display("FAIL fill_ovf: got ovf=%b free=%0d want ovf=1 free=0", bus.overflow, bus.free_slots);
        end
        for (int i = 0; i < DEPTH * N; i++) begin
            exp_s = expect_stream();
            got_s = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
            applied++;
            if (got_s !== exp_s) begin
                miscompares++;
                $display("FAIL fill_data[%0d]: got %h want %h", i, got_s, exp_s);
            end
            drive_cycle(0, ZERO, 1);
        end
        applied++;
        if ({bus.out_valid, bus.overflow} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL fill_end: got valid=%b ovf=%b want valid=0 ovf=1", bus.out_valid, bus.overflow);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int v = 0; v < DEPTH; v++) drive_cycle(1, mkvec(8'(8'h40 + 8'h10 * v)), 0);
        for (int i = 0; i < N - 1; i++) drive_cycle(0, ZERO, 1);
        applied++;
        if ({bus.out_idx, bus.free_slots} !== {4'd15, 3'd0}) begin
            miscompares++;
            $display("FAIL b2b_pre: got idx=%0d free=%0d want idx=15 free=0", bus.out_idx, bus.free_slots);
        end
        drive_cycle(1, mkvec(8'h80), 1);
        applied++;
        if ({bus.free_slots, bus.overflow} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_accept: got free=%0d ovf=%b want free=0 ovf=0", bus.free_slots, bus.overflow);
        end
        for (int i = 0; i < DEPTH * N; i++) begin
            exp_s = expect_stream();
            got_s = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
            applied++;
            if (got_s !== exp_s || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %h want %h", i, got_s, exp_s);
            end
            drive_cycle(0, ZERO, 1);
        end
        applied++;
        if ({bus.out_valid, bus.free_slots, bus.overflow} !== {1'b0, 3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_end: got valid=%b free=%0d ovf=%b want 0/4/0", bus.out_valid, bus.free_slots, bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int v = 0; v < 3; v++) drive_cycle(1, mkvec(8'(8'h30 + 8'h20 * v)), 0);
        for (int i = 0; i < N + 7; i++) drive_cycle(0, ZERO, 1);
        applied++;
        if ({bus.out_idx, bus.out_data} !== {4'd7, 8'h57}) begin
            miscompares++;
            $display("FAIL mid_pre: got idx=%0d data=%h want idx=7 data=57", bus.out_idx, bus.out_data);
        end
        bus.out_ready = 0;
        rst = 1;
        model_reset();
        #1;
        got_s = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
        applied++;
        if ({got_s, bus.free_slots} !== {14'h0, 3'd4}) begin
            miscompares++;
            $display("FAIL mid_async: got %h free=%0d want 0000 free=4", got_s, bus.free_slots);
        end
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, ZERO, 1);
            applied++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_idle[%0d]: got valid=%b want 0", i, bus.out_valid);
            end
        end
        drive_cycle(1, mkvec(8'hC0), 1);
        for (int i = 0; i < N; i++) begin
            exp_s = expect_stream();
            got_s = {bus.out_valid, bus.out_data, bus.out_idx, bus.out_last};
            applied++;
            if (got_s !== exp_s) begin
                miscompares++;
                $display("FAIL mid_new[%0d]: got %h want %h", i, got_s, exp_s);
            end
            drive_cycle(0, ZERO, 1);
        end
        applied++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_end: got valid=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
